mdio_master: RTL and testbench

Clause 22 MDIO management station: accepts one read or write command at a time over a valid/ready handshake and serializes it onto MDC/MDIO. It samples the PHY's turnaround and read data, and returns a one-cycle response. It sits on the MAC/management side of the link and drives the MDIO bus that the PHY-side register block answers. The pad-level tristate (mdo/mdo_oe/mdi) is resolved outside this block.

---
 rtl/mdio_master.sv | 160 ++++++++++++++++
 tb/tb_mdio_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// Clause 22 MDIO management station: one read/write command per frame,
// serialized onto MDC/MDIO, with a one-cycle response at end of frame.
module mdio_master #(
  parameter int unsigned CLK_DIV       = 5,
  parameter int unsigned PREAMBLE_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdo,
  output logic        mdo_oe,
  input  logic        mdi
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0] PRE_LAST  = 6'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam logic [5:0] HDR_LAST  = 6'd13;
  localparam logic [5:0] TA_LAST   = 6'd1;
  localparam logic [5:0] DATA_LAST = 6'd15;

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, RESP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [31:0]      sh;
  logic             we_q;
  logic [15:0]      rd_sh;
  logic             ta_err;
  logic [31:0]      frame_c;

  // Post-preamble frame image; read TA/data slots are ones since the bus is released there.
  assign frame_c = {2'b01, (cmd_we ? 2'b01 : 2'b10), cmd_phyad, cmd_regad,
                    (cmd_we ? 2'b10 : 2'b11), (cmd_we ? cmd_data : 16'hFFFF)};

  // Frame sequencer: MDC divider, bit shifting, PHY sampling and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      we_q      <= 1'b0;
      rd_sh     <= '0;
      ta_err    <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      mdc       <= 1'b0;
      mdo       <= 1'b1;
      mdo_oe    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            we_q      <= cmd_we;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            ta_err    <= 1'b0;
            mdc       <= 1'b0;
            mdo_oe    <= 1'b1;
            if (PREAMBLE_BITS == 0) begin
              state <= HDR;
              mdo   <= frame_c[31];
              sh    <= {frame_c[30:0], 1'b0};
            end else begin
              state <= PRE;
              mdo   <= 1'b1;
              sh    <= frame_c;
            end
          end
        end
        RESP: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        PRE, HDR, TA, DATA: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!mdc) begin
              // Rising MDC edge: PHY data is sampled on this same clk edge.
              mdc <= 1'b1;
              if (state == TA && bit_cnt == TA_LAST) ta_err <= mdi;
              if (state == DATA) rd_sh <= {rd_sh[14:0], mdi};
            end else begin
              // Falling MDC edge: launch the next bit.
              mdc <= 1'b0;
              case (state)
                PRE: begin
                  if (bit_cnt == PRE_LAST) begin
                    state   <= HDR;
                    bit_cnt <= '0;
                    mdo     <= sh[31];
                    sh      <= {sh[30:0], 1'b0};
                  end else begin
                    bit_cnt <= bit_cnt + 6'd1;
                    mdo     <= 1'b1;
                  end
                end
                HDR: begin
                  mdo <= sh[31];
                  sh  <= {sh[30:0], 1'b0};
                  if (bit_cnt == HDR_LAST) begin
                    state   <= TA;
                    bit_cnt <= '0;
                    mdo_oe  <= we_q;
                  end else begin
                    bit_cnt <= bit_cnt + 6'd1;
                  end
                end
                TA: begin
                  mdo <= sh[31];
                  sh  <= {sh[30:0], 1'b0};
                  if (bit_cnt == TA_LAST) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                  end else begin
                    bit_cnt <= bit_cnt + 6'd1;
                  end
                end
                default: begin
                  if (bit_cnt == DATA_LAST) begin
                    state     <= RESP;
                    bit_cnt   <= '0;
                    mdo       <= 1'b1;
                    mdo_oe    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= we_q ? 16'h0000 : rd_sh;
                    rsp_err   <= we_q ? 1'b0 : ta_err;
                  end else begin
                    mdo     <= sh[31];
                    sh      <= {sh[30:0], 1'b0};
                    bit_cnt <= bit_cnt + 6'd1;
                  end
                end
              endcase
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: frame vectors, back-to-back, abort, no-preamble.
module tb_mdio_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [4:0]  cmd_phyad, cmd_regad;
  logic [15:0] cmd_data;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_data;
  logic        mdc, mdo, mdo_oe, mdi;

  logic        b_cmd_valid, b_cmd_ready, b_cmd_we;
  logic [4:0]  b_cmd_phyad, b_cmd_regad;
  logic [15:0] b_cmd_data;
  logic        b_rsp_valid, b_rsp_err;
  logic [15:0] b_rsp_data;
  logic        b_mdc, b_mdo, b_mdo_oe, b_mdi;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(2), .PREAMBLE_BITS(32)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .mdc(mdc), .mdo(mdo), .mdo_oe(mdo_oe), .mdi(mdi)
  );

  mdio_master #(.CLK_DIV(1), .PREAMBLE_BITS(0)) u_dut_np (
    .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_we(b_cmd_we), .cmd_phyad(b_cmd_phyad), .cmd_regad(b_cmd_regad),
    .cmd_data(b_cmd_data), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .rsp_err(b_rsp_err), .mdc(b_mdc), .mdo(b_mdo), .mdo_oe(b_mdo_oe), .mdi(b_mdi)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [15:0] data;
    logic        phy_en;
    logic [15:0] phy_val;
    logic [31:0] exp_frame;
    logic [31:0] exp_mask;
    logic [63:0] exp_oe;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // PHY model by bit position: 0 on second TA bit, then the register value MSB first.
  function automatic logic phy_bit(input logic en, input logic [15:0] val, input int idx);
    if (!en) return 1'b1;
    if (idx == 47) return 1'b0;
    if (idx >= 48 && idx <= 63) return val[4'(63 - idx)];
    return 1'b1;
  endfunction

  task automatic start_cmd(input logic we, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] d, input logic hold);
    int w = 0;
    @(negedge clk);
    cmd_we = we; cmd_phyad = pa; cmd_regad = ra; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_hs", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Runs from just after the handshake edge; captures mdo/mdo_oe at each MDC rise.
  task automatic wait_frame(input logic phy_en, input logic [15:0] phy_val, input int stop_bit,
                            output int len, output logic [63:0] cmdo, output logic [63:0] coe,
                            output int nbits);
    int   t    = 0;
    int   nb   = 0;
    logic prev = 1'b0;
    len = 0; cmdo = '0; coe = '0;
    while (t < 2000) begin
      @(negedge clk);
      t++;
      if (t == 1) chk("ready_low_t1", 64'(cmd_ready), 64'd0);
      if (mdc && !prev && nb < 64) begin
        cmdo[6'(63 - nb)] = mdo;
        coe[6'(63 - nb)]  = mdo_oe;
        nb++;
      end
      if (!mdc && prev) mdi = phy_bit(phy_en, phy_val, nb);
      prev = mdc;
      if (rsp_valid) begin
        len = t;
        break;
      end
      if (stop_bit >= 0 && nb >= stop_bit) break;
    end
    nbits = nb;
    mdi = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int          len, nb;
    logic [63:0] cm, co;
    start_cmd(v.we, v.phyad, v.regad, v.data, 1'b0);
    wait_frame(v.phy_en, v.phy_val, -1, len, cm, co, nb);
    chk({tag, "_len"}, 64'(len), 64'd257);
    chk({tag, "_preamble"}, 64'(cm[63:32]), 64'hFFFF_FFFF);
    chk({tag, "_frame"}, 64'(cm[31:0] & v.exp_mask), 64'(v.exp_frame));
    chk({tag, "_oe"}, co, v.exp_oe);
    chk({tag, "_rdata"}, 64'(rsp_data), 64'(v.exp_rdata));
    chk({tag, "_err"}, 64'(rsp_err), 64'(v.exp_err));
    chk({tag, "_resp_bus"}, 64'({mdc, mdo, mdo_oe}), 64'b010);
    @(negedge clk);
    chk({tag, "_after_rsp"}, 64'({rsp_valid, cmd_ready}), 64'b01);
    chk({tag, "_held"}, 64'({rsp_err, rsp_data}), 64'({v.exp_err, v.exp_rdata}));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          len, nb, t;
    logic [63:0] cm, co;
    logic [31:0] bcap;
    logic        prev, seen;

    vecs[0] = '{we:1'b1, phyad:5'h01, regad:5'h00, data:16'h8000, phy_en:1'b0, phy_val:16'h0,
                exp_frame:32'h5082_8000, exp_mask:32'hFFFF_FFFF, exp_oe:64'hFFFF_FFFF_FFFF_FFFF,
                exp_rdata:16'h0000, exp_err:1'b0};
    vecs[1] = '{we:1'b0, phyad:5'h03, regad:5'h02, data:16'hDEAD, phy_en:1'b1, phy_val:16'h1234,
                exp_frame:32'h6188_0000, exp_mask:32'hFFFC_0000, exp_oe:64'hFFFF_FFFF_FFFC_0000,
                exp_rdata:16'h1234, exp_err:1'b0};
    vecs[2] = '{we:1'b0, phyad:5'h1F, regad:5'h1F, data:16'h0000, phy_en:1'b0, phy_val:16'h0,
                exp_frame:32'h6FFC_0000, exp_mask:32'hFFFC_0000, exp_oe:64'hFFFF_FFFF_FFFC_0000,
                exp_rdata:16'hFFFF, exp_err:1'b1};
    vecs[3] = '{we:1'b1, phyad:5'h15, regad:5'h0A, data:16'hA5C3, phy_en:1'b0, phy_val:16'h0,
                exp_frame:32'h5AAA_A5C3, exp_mask:32'hFFFF_FFFF, exp_oe:64'hFFFF_FFFF_FFFF_FFFF,
                exp_rdata:16'h0000, exp_err:1'b0};
    vecs[4] = '{we:1'b0, phyad:5'h00, regad:5'h1F, data:16'h0000, phy_en:1'b1, phy_val:16'hBEEF,
                exp_frame:32'h607C_0000, exp_mask:32'hFFFC_0000, exp_oe:64'hFFFF_FFFF_FFFC_0000,
                exp_rdata:16'hBEEF, exp_err:1'b0};

    rst = 1'b1; mdi = 1'b1; b_mdi = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_phyad = '0; cmd_regad = '0; cmd_data = '0;
    b_cmd_valid = 1'b0; b_cmd_we = 1'b0; b_cmd_phyad = '0; b_cmd_regad = '0; b_cmd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a", 64'({cmd_ready, rsp_valid, rsp_data, rsp_err, mdc, mdo, mdo_oe}),
        64'({1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0}));
    chk("reset_b", 64'({b_cmd_ready, b_rsp_valid, b_rsp_data, b_rsp_err, b_mdc, b_mdo, b_mdo_oe}),
        64'({1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0}));
    rst = 1'b0;

    for (int i = 0; i < 5; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back with cmd_valid held; cmd_* changed right after the first handshake.
    start_cmd(1'b1, 5'h01, 5'h00, 16'h8000, 1'b1);
    cmd_phyad = 5'h15; cmd_regad = 5'h0A; cmd_data = 16'hA5C3;
    wait_frame(1'b0, 16'h0, -1, len, cm, co, nb);
    chk("b2b_f1_len", 64'(len), 64'd257);
    chk("b2b_f1_frame", 64'(cm[31:0]), 64'h5082_8000);
    @(negedge clk);
    chk("b2b_ready_after_rsp", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_frame(1'b0, 16'h0, -1, len, cm, co, nb);
    chk("b2b_f2_len", 64'(len), 64'd257);
    chk("b2b_f2_frame", 64'(cm[31:0]), 64'h5AAA_A5C3);
    @(negedge clk);

    // Reset pulsed around bit 40 of a read aborts the frame.
    start_cmd(1'b0, 5'h03, 5'h02, 16'h0, 1'b0);
    wait_frame(1'b1, 16'h1234, 40, len, cm, co, nb);
    chk("abort_reached_bit40", 64'(nb), 64'd40);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_bus", 64'({mdc, mdo_oe, cmd_ready, rsp_valid}), 64'b0010);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("abort_no_rsp", 64'(seen), 64'd0);
    apply_vec(vecs[0], "post_abort");

    // No preamble, CLK_DIV = 1 instance.
    @(negedge clk);
    b_cmd_we = 1'b1; b_cmd_phyad = 5'h01; b_cmd_regad = 5'h00; b_cmd_data = 16'h8000;
    b_cmd_valid = 1'b1;
    chk("np_ready", 64'(b_cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    b_cmd_valid = 1'b0;
    t = 0; nb = 0; prev = 1'b0; bcap = '0; len = 0;
    while (t < 500) begin
      @(negedge clk);
      t++;
      if (b_mdc && !prev && nb < 32) begin
        bcap[5'(31 - nb)] = b_mdo;
        nb++;
      end
      prev = b_mdc;
      if (b_rsp_valid) begin
        len = t;
        break;
      end
    end
    chk("np_len", 64'(len), 64'd65);
    chk("np_bits", 64'(nb), 64'd32);
    chk("np_frame", 64'(bcap), 64'h5082_8000);
    chk("np_rsp", 64'({b_rsp_err, b_rsp_data}), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
